// File: rtl/io_port_arbiter.sv
// -----------------------------------------------------------------------------
// io_port_arbiter
//   Lets two requesters share the write port (io_D/io_addr/io_WE) and the A-side
//   read select (io_cha/io_Da) of a 4-register I/O block. Requester 0 is the CPU
//   core and requester 1 is the config/DMA engine.
//
//   Arbitration is round-robin, and only one transaction is in flight at a time.
//   Reads take a cycle longer than writes because the I/O block registers the
//   read select before its data appears. Requester 1 may not write the
//   direction/enable register at address 0: such a write completes with err=1
//   and never reaches the I/O block.
//
//   Ports:
//     clk, rst                    clock and synchronous active-high reset
//     rN_req/we/addr/wdata        request from requester N (req held until gnt)
//     rN_gnt                      combinational accept pulse, only in IDLE
//     rN_done/err/rdata           registered completion pulse, error, read data
//     io_D/io_addr/io_WE          write port to the I/O block
//     io_cha / io_Da              A-side read select and read data
//     busy                        a transaction is in progress
// -----------------------------------------------------------------------------

// Completion and read-data registers for one requester.
module io_port_resp #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fin,       // last cycle of a transaction owned by us
  input  logic          fin_err,   // that transaction was refused
  input  logic          cap,       // io_Da is valid and belongs to us
  input  logic [DW-1:0] cap_data,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata
);
  always_ff @(posedge clk) begin
    if (rst) begin
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      done <= fin;
      err  <= fin & fin_err;
      // rdata is sticky: it only changes when one of our reads completes
      if (cap) rdata <= cap_data;
    end
  end
endmodule

module io_port_arbiter #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_done,
  output logic          r0_err,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_done,
  output logic          r1_err,
  output logic [DW-1:0] r1_rdata,
  output logic [DW-1:0] io_D,
  output logic [AW-1:0] io_addr,
  output logic          io_WE,
  output logic [AW-1:0] io_cha,
  input  logic [DW-1:0] io_Da,
  output logic          busy
);
  localparam int NREQ = 2;

  typedef enum logic [1:0] {IDLE, WR, RD_SEL, RD_CAP} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t                   state;
  logic                     last;      // id of the most recent grant
  logic                     own;       // id of the in-flight transaction
  logic [AW-1:0]            cur_addr;  // latched target register
  logic [NREQ-1:0]          req_v;
  req_t [NREQ-1:0]          req_in;
  logic [NREQ-1:0]          gnt;
  logic                     gnt_id;
  req_t                     sel;
  logic                     prot;
  logic [NREQ-1:0]          fin;
  logic [NREQ-1:0]          cap;
  logic [NREQ-1:0]          done_v;
  logic [NREQ-1:0]          err_v;
  logic [NREQ-1:0][DW-1:0]  rdata_v;

  assign req_v     = {r1_req, r0_req};
  assign req_in[0] = '{we: r0_we, addr: r0_addr, wdata: r0_wdata};
  assign req_in[1] = '{we: r1_we, addr: r1_addr, wdata: r1_wdata};

  // Grant only from IDLE. On a tie the requester that did not win last time
  // wins; last resets to 1 so requester 0 takes the first tie.
  always_comb begin
    gnt = '0;
    if (!rst && state == IDLE) begin
      if (&req_v) begin
        if (last) gnt[0] = 1'b1;
        else      gnt[1] = 1'b1;
      end else begin
        gnt = req_v;
      end
    end
  end

  assign gnt_id = gnt[1];
  assign sel    = gnt_id ? req_in[1] : req_in[0];

  // Requester 1 writing address 0 is refused.
  assign prot = own & (cur_addr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      own      <= 1'b0;
      cur_addr <= '0;
      io_WE    <= 1'b0;
      io_D     <= '0;
      io_addr  <= '0;
      io_cha   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            own      <= gnt_id;
            last     <= gnt_id;
            cur_addr <= sel.addr;
            if (sel.we) begin
              state   <= WR;
              io_addr <= sel.addr;
              io_D    <= sel.wdata;
              // The strobe is registered here so it lines up with WR; a
              // refused write simply never raises it.
              io_WE   <= !(gnt_id && sel.addr == '0);
            end else begin
              state  <= RD_SEL;
              io_cha <= sel.addr;
            end
          end
        end
        WR: begin
          io_WE <= 1'b0;
          state <= IDLE;
        end
        RD_SEL:  state <= RD_CAP;  // I/O block registers io_cha this cycle
        RD_CAP:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // One response block per requester. fin/cap are decoded from the current
  // state so the registered done lands one cycle after WR or RD_CAP.
  for (genvar i = 0; i < NREQ; i++) begin : g_resp
    assign fin[i] = (state == WR || state == RD_CAP) && (own == 1'(i));
    assign cap[i] = (state == RD_CAP) && (own == 1'(i));

    io_port_resp #(.DW(DW)) u_resp (
      .clk      (clk),
      .rst      (rst),
      .fin      (fin[i]),
      .fin_err  (state == WR && prot),
      .cap      (cap[i]),
      .cap_data (io_Da),
      .done     (done_v[i]),
      .err      (err_v[i]),
      .rdata    (rdata_v[i])
    );
  end

  assign r0_gnt   = gnt[0];
  assign r1_gnt   = gnt[1];
  assign r0_done  = done_v[0];
  assign r1_done  = done_v[1];
  assign r0_err   = err_v[0];
  assign r1_err   = err_v[1];
  assign r0_rdata = rdata_v[0];
  assign r1_rdata = rdata_v[1];
endmodule

// File: doc/io_port_arbiter.md
Name: io_port_arbiter

Overview:
- Shares the single write port (D/addr/WE) and the A-side read select (cha/Da) of the 4-register I/O block between two requesters.
- Requester 0 is the CPU core. Requester 1 is the config/DMA engine.
- Round-robin arbitration, one transaction in flight at a time.
- Sequences the one-cycle registered read-select latency of the I/O block and protects the direction/enable register (address 0) from requester 1.

Parameters:
- DW, 8, data width of I/O registers and requester data.
- AW, 2, I/O register address width (4 registers).

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- r0_req  in  1  requester 0 transaction request, held until r0_gnt
- r0_we  in  1  1 = write, 0 = read
- r0_addr  in  AW  target register
- r0_wdata  in  DW  write data
- r0_gnt  out  1  accept pulse
- r0_done  out  1  completion pulse
- r0_err  out  1  valid with r0_done; always 0 for requester 0
- r0_rdata  out  DW  read data, valid when r0_done and read
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_done, r1_err, r1_rdata: same as r0_*, for requester 1
- io_D  out  DW  write data to I/O block
- io_addr  out  AW  write address to I/O block
- io_WE  out  1  write enable to I/O block
- io_cha  out  2  A-side read select to I/O block
- io_Da  in  DW  A-side read data from I/O block
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: synchronous, active-high, on clk posedge. Values while rst is high and after its release:
  - state=IDLE
  - rN_gnt=0, rN_done=0, rN_err=0, rN_rdata=0
  - io_WE=0, io_D=0, io_addr=0, io_cha=0, busy=0
  - rr pointer last=1, so requester 0 wins the first tie.
- Reset mid-transaction: the transaction is abandoned. No io_WE after reset, no done, no err.
- States: IDLE, WR, RD_SEL, RD_CAP.
- IDLE:
  - rN_gnt is Mealy: asserted combinationally in the cycle it is granted.
  - Only one of r0_req/r1_req high: grant it.
  - Both high: grant the requester not equal to last.
  - On grant, at the clock edge:
    - latch we, addr, wdata and the owner id;
    - set last=owner;
    - go to WR if we=1, else RD_SEL.
  - No grant while rst is high.
- WR (1 cycle):
  - Normal case: io_WE=1, io_addr and io_D driven from the latched fields. The I/O register updates at the end of this cycle.
  - Protected write (owner=1 and addr=0): io_WE stays 0 and err is flagged.
  - Next state: IDLE.
- RD_SEL (1 cycle): io_cha=latched addr. The I/O block registers the select at the end of this cycle. Next state: RD_CAP.
- RD_CAP (1 cycle): io_Da is valid. Capture io_Da into the owner's rdata register at the end of the cycle. Next state: IDLE.
- io_cha holds its last driven value outside reads. io_addr/io_D hold their last values. io_WE is 0 outside WR.
- Completion:
  - Owner's done is a registered pulse, one cycle after WR or RD_CAP.
  - err is driven with done.
  - rdata holds until the next read completes for that requester.
  - The done cycle coincides with IDLE, so a new grant may occur in the same cycle.
- Latency, grant at cycle T:
  - Write: io_WE at T+1, done at T+2.
  - Read: io_cha at T+1, capture at end of T+2, done/rdata at T+3.
- Throughput: back-to-back writes grant every 2 cycles; reads every 3 cycles.
- Read-after-write to the same address returns the new value. No hazard because transactions are serialized.
- Requests arriving while busy wait. req must stay high until gnt; fields are sampled only in the grant cycle.
- A requester dropping req before gnt is legal: no transaction occurs.
- busy=1 in WR, RD_SEL and RD_CAP.

Test Plan:
- Reset, r0 write addr1=0x5A: r0_gnt at T, io_WE=1/io_addr=1/io_D=0x5A at T+1, r0_done=1 and r0_err=0 at T+2; then r0 read addr1 gives io_cha=1 at T+1 and r0_rdata=0x5A with r0_done at T+3.
- Both requesters assert writes every cycle (r0 to addr3, r1 to addr2): grants alternate r0, r1, r0, r1, with grants 2 cycles apart; the first grant goes to r0.
- r1 write addr0=0xFF: io_WE stays 0 throughout, r1_done=1 with r1_err=1, Q0 unchanged. The same write from r0 succeeds with err=0.
- r1 read addr3 with r0 write addr3=0x33 pending (r0 granted first): r1_rdata=0x33.
- Assert rst during RD_SEL: next cycle state=IDLE, busy=0, no r0_done. A subsequent request gets granted normally.
- r0_req pulses for one cycle while busy and drops before IDLE: no grant and no io_WE are issued.
